univ_shift_reg: RTL and testbench

//   Parametrised universal shift register: a WIDTH-bit register with per-cycle modes.

---
 rtl/univ_shift_reg_pkg.sv | 26 ++
 rtl/univ_shift_reg_if.sv | 30 +++
 rtl/univ_shift_reg_chk.sv | 16 +
 rtl/univ_shift_reg.sv | 82 ++++++++
 tb/tb_univ_shift_reg.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared types and helpers for the universal shift register.
package usr_pkg;

   // Operation select. Code 3'b111 is reserved and acts like HOLD.
   typedef enum logic [2:0] {
      HOLD = 3'b000,
      SHR  = 3'b001,
      SHL  = 3'b010,
      LOAD = 3'b011,
      ROTR = 3'b100,
      ROTL = 3'b101,
      ASR  = 3'b110,
      RSVD = 3'b111
   } usr_mode_e;

   // True for the modes that move bits and therefore advance the shift counter.
   function automatic logic is_shift(input usr_mode_e mode);
      logic r_res;
      case (mode)
         SHR, SHL, ROTR, ROTL, ASR: r_res = 1'b1;
         default:                   r_res = 1'b0;
      endcase
      return r_res;
   endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register.
interface univ_shift_reg_if
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             en;
   logic             clr;
   usr_mode_e        mode;
   logic             sin_l;
   logic             sin_r;
   logic [WIDTH-1:0] pdin;
   logic [WIDTH-1:0] q;
   logic             sout_l;
   logic             sout_r;
   logic [CW-1:0]    shift_cnt;
   logic             cnt_full;

   modport master (
      output en, clr, mode, sin_l, sin_r, pdin,
      input  q, sout_l, sout_r, shift_cnt, cnt_full
   );

   modport slave (
      input  en, clr, mode, sin_l, sin_r, pdin,
      output q, sout_l, sout_r, shift_cnt, cnt_full
   );
endinterface

// File: rtl/univ_shift_reg_chk.sv
// Simulation-only checks on the shift register control inputs.
module univ_shift_reg_chk
   import usr_pkg::*;
(
   input logic      clk,
   input logic      rst,
   input logic      en,
   input usr_mode_e mode
);

   // An enabled cycle must present a fully known mode.
   a_mode_known : assert property (@(posedge clk) disable iff (!rst)
      en |-> !$isunknown(mode))
      else $error("univ_shift_reg: unknown mode with en=1");

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register with sync clear, enable and a
// saturating count of shifts since the last load or clear.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
)(
   input logic               clk,
   input logic               rst,
   univ_shift_reg_if.slave   bus
);

   localparam int            CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   if (WIDTH < 2) begin : g_width_chk
      $error("univ_shift_reg: WIDTH must be >= 2");
   end

   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] w_q_nxt;
   logic [CW-1:0]    w_cnt_nxt;

   // Next-state decode: clear beats enable, enable gates the mode table.
   always_comb begin
      w_q_nxt   = r_q;
      w_cnt_nxt = r_cnt;
      if (bus.clr) begin
         w_q_nxt   = RST_VAL;
         w_cnt_nxt = {CW{1'b0}};
      end else if (!bus.en) begin
         w_q_nxt   = r_q;
         w_cnt_nxt = r_cnt;
      end else begin
         case (bus.mode)
            SHR:     w_q_nxt = {bus.sin_l, r_q[WIDTH-1:1]};
            SHL:     w_q_nxt = {r_q[WIDTH-2:0], bus.sin_r};
            LOAD:    w_q_nxt = bus.pdin;
            ROTR:    w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
            ROTL:    w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            ASR:     w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            default: w_q_nxt = r_q;   // HOLD, reserved, or unknown code
         endcase
         if (is_shift(bus.mode)) begin
            // Saturate rather than wrap so cnt_full stays asserted.
            w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
         end else if (bus.mode == LOAD) begin
            w_cnt_nxt = {CW{1'b0}};
         end else begin
            w_cnt_nxt = r_cnt;
         end
      end
   end

   // State register; asynchronous active-low reset discards everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q   <= RST_VAL;
         r_cnt <= {CW{1'b0}};
      end else begin
         r_q   <= w_q_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   assign bus.q         = r_q;
   assign bus.shift_cnt = r_cnt;
   assign bus.sout_l    = r_q[WIDTH-1];
   assign bus.sout_r    = r_q[0];
   assign bus.cnt_full  = (r_cnt == CNT_MAX);

   univ_shift_reg_chk u_chk (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.en),
      .mode (bus.mode)
   );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RST_VAL=0).
module tb_univ_shift_reg;
   import usr_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   // Behavioural model state, plain integers.
   int   m_q;
   int   m_cnt;

   univ_shift_reg_if #(.WIDTH(8)) bus ();

   univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       clr;
      logic       en;
      logic [2:0] mode;
      logic       sl;
      logic       sr;
      logic [7:0] pd;
      logic [7:0] eq;
      int         ec;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model of one clock edge, written as arithmetic on integers.
   task automatic model_step(input logic en, input logic clr, input logic [2:0] mode,
                             input logic sl, input logic sr, input logic [7:0] pd);
      int q;
      q = m_q;
      if (!rst) begin
         m_q = 0; m_cnt = 0;
      end else if (clr) begin
         m_q = 0; m_cnt = 0;
      end else if (en) begin
         case (mode)
            3'd1: m_q = (q >> 1) | (int'(sl) << 7);
            3'd2: m_q = ((q << 1) & 255) | int'(sr);
            3'd3: m_q = int'(pd);
            3'd4: m_q = (q >> 1) | ((q & 1) << 7);
            3'd5: m_q = ((q << 1) & 255) | (q >> 7);
            3'd6: m_q = (q >> 1) | (q & 128);
            default: m_q = q;
         endcase
         if (mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
         else if (mode == 3'd3) m_cnt = 0;
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".q"},      32'(bus.q),         32'(m_q));
      chk({tag, ".cnt"},    32'(bus.shift_cnt), 32'(m_cnt));
      chk({tag, ".sout_l"}, 32'(bus.sout_l),    32'((m_q >> 7) & 1));
      chk({tag, ".sout_r"}, 32'(bus.sout_r),    32'(m_q & 1));
      chk({tag, ".full"},   32'(bus.cnt_full),  32'(m_cnt == 8));
   endtask

   // Drive one cycle of inputs, clock it, advance the model, compare.
   task automatic apply(input string tag, input logic en, input logic clr, input logic [2:0] mode,
                        input logic sl, input logic sr, input logic [7:0] pd);
      bus.en = en; bus.clr = clr; bus.mode = usr_mode_e'(mode);
      bus.sin_l = sl; bus.sin_r = sr; bus.pdin = pd;
      @(posedge clk);
      #1;
      model_step(en, clr, mode, sl, sr, pd);
      chk_model(tag);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; m_q = 0; m_cnt = 0;
      rst = 1'b0;
      bus.en = 1'b0; bus.clr = 1'b0; bus.mode = HOLD;
      bus.sin_l = 1'b0; bus.sin_r = 1'b0; bus.pdin = 8'h00;

      // Directed vectors: {clr, en, mode, sin_l, sin_r, pdin, exp q, exp cnt}.
      tbl[0]  = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'hA5, 8'hA5, 0};
      tbl[1]  = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 8'hD2, 1};
      tbl[2]  = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'hA5, 8'hA5, 0};
      tbl[3]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00, 8'h4A, 1};
      tbl[4]  = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'h81, 8'h81, 0};
      tbl[5]  = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 8'h00, 8'hC0, 1};
      tbl[6]  = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'h81, 8'h81, 0};
      tbl[7]  = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 8'h00, 8'h03, 1};
      tbl[8]  = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'h80, 8'h80, 0};
      tbl[9]  = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 8'hC0, 1};
      tbl[10] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 8'hE0, 2};
      tbl[11] = '{1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'hFF, 8'h00, 0};
      tbl[12] = '{1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 8'hFF, 8'h00, 0};

      // Reset state while rst is held low.
      #12;
      chk("rst.q",    32'(bus.q),         32'h0);
      chk("rst.cnt",  32'(bus.shift_cnt), 32'h0);
      chk("rst.full", 32'(bus.cnt_full),  32'h0);
      rst = 1'b1;

      for (int i = 0; i < 13; i++) begin
         apply($sformatf("tbl%0d", i), tbl[i].en, tbl[i].clr, tbl[i].mode,
               tbl[i].sl, tbl[i].sr, tbl[i].pd);
         chk($sformatf("tbl%0d.q_const", i),   32'(bus.q),         32'(tbl[i].eq));
         chk($sformatf("tbl%0d.cnt_const", i), 32'(bus.shift_cnt), 32'(tbl[i].ec));
      end

      // Asynchronous reset between edges with q=0x5A, cnt=3.
      apply("ar.load", 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'h4B);
      for (int i = 0; i < 3; i++) apply("ar.rotl", 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 8'h00);
      chk("ar.pre_q",   32'(bus.q),         32'h5A);
      chk("ar.pre_cnt", 32'(bus.shift_cnt), 32'h3);
      #2;
      rst = 1'b0;
      #1;
      m_q = 0; m_cnt = 0;
      chk("ar.now_q",   32'(bus.q),         32'h0);
      chk("ar.now_cnt", 32'(bus.shift_cnt), 32'h0);
      apply("ar.held", 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'hFF);
      #2;
      rst = 1'b1;
      apply("ar.first", 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'h3C);
      chk("ar.first_q", 32'(bus.q), 32'h3C);

      // Counter saturation across 10 shifts, then LOAD clears it.
      apply("sat.load", 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= 10; i++) begin
         apply($sformatf("sat.shr%0d", i), 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 8'h00);
         chk($sformatf("sat.cnt%0d", i),  32'(bus.shift_cnt), 32'((i < 8) ? i : 8));
         chk($sformatf("sat.full%0d", i), 32'(bus.cnt_full),  32'(i >= 8));
      end
      apply("sat.reload", 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'h11);
      chk("sat.reload_full", 32'(bus.cnt_full), 32'h0);

      // Enable low with SHR: hold for 5 cycles; then reserved mode holds 3 cycles.
      apply("hold.shift", 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) begin
         apply("hold.en0", 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 8'hFF);
         chk("hold.en0_q",   32'(bus.q),         32'h88);
         chk("hold.en0_cnt", 32'(bus.shift_cnt), 32'h1);
      end
      for (int i = 0; i < 3; i++) begin
         apply("rsvd", 1'b1, 1'b0, 3'd7, 1'b1, 1'b1, 8'hFF);
         chk("rsvd_q",   32'(bus.q),         32'h88);
         chk("rsvd_cnt", 32'(bus.shift_cnt), 32'h1);
      end

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         apply("rnd", ($urandom_range(3, 0) != 0), ($urandom_range(15, 0) == 0),
               3'($urandom_range(7, 0)), 1'($urandom), 1'($urandom), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
